// File: rtl/ivlbc_decrypt.sv
// Iterative IVLBC decryption core: expands the 80-bit key forward, then runs inverse rounds backwards.
// Optional macro KEY_CACHE_EN keeps the last master key and its final round key to skip expansion.
module ivlbc_decrypt #(
    parameter int ROUNDS = 25,
    parameter int CNT_W  = 5
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    input  logic         decrypt_start,
    input  logic [63:0]  state,
    input  logic [79:0]  keys,
    output logic         decrypt_end,
    output logic [63:0]  result,
    output logic         busy,
    output logic [2:0]   dbg_state
);

    // Handshake: decrypt_start is a level request sampled only in IDLE; decrypt_end stays high in DONE
    // until decrypt_start is seen low, so a held request never retriggers without one low edge.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KEYEXP = 3'd1;
    localparam logic [2:0] S_DEC    = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        case (x)
            4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
            4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
            4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
            4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
        endcase
    endfunction

    function automatic logic [79:0] key_update(input logic [79:0] k, input logic [CNT_W-1:0] i);
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = sbox(t[79:76]);
        t[19:15] = t[19:15] ^ 5'(i);
        return t;
    endfunction

    function automatic logic [79:0] inv_key_update(input logic [79:0] k, input logic [CNT_W-1:0] i);
        logic [79:0] t;
        t = k;
        t[19:15] = t[19:15] ^ 5'(i);
        t[79:76] = sbox_inv(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

    // Forward P-layer sends bit j to (16*j) mod 63 (bit 63 fixed); undo it by gathering from there.
    function automatic logic [63:0] inv_round(input logic [63:0] d);
        logic [63:0] p;
        logic [63:0] o;
        logic [5:0]  src;
        logic [5:0]  b;
        p = '0;
        o = '0;
        for (int j = 0; j < 64; j++) begin
            src = (j == 63) ? 6'd63 : 6'((j * 16) % 63);
            p[j[5:0]] = d[src];
        end
        for (int n = 0; n < 16; n++) begin
            b = 6'(n * 4);
            o[b +: 4] = sbox_inv(p[b +: 4]);
        end
        return o;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      d_q, d_d;
    logic [79:0]      k_q, k_d;
    logic [63:0]      result_q, result_d;
    logic             end_q, end_d;
    logic [79:0]      k_fwd;

`ifdef KEY_CACHE_EN
    logic [79:0] mkey_q, mkey_d;
    logic [79:0] cache_key_q, cache_key_d;
    logic [79:0] cache_rk_q, cache_rk_d;
    logic        cache_valid_q, cache_valid_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        k_d      = k_q;
        result_d = result_q;
        end_d    = end_q;
        k_fwd    = key_update(k_q, cnt_q);
`ifdef KEY_CACHE_EN
        mkey_d        = mkey_q;
        cache_key_d   = cache_key_q;
        cache_rk_d    = cache_rk_q;
        cache_valid_d = cache_valid_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (decrypt_start) begin
                    d_d     = state;
                    k_d     = keys;
                    cnt_d   = CNT_ONE;
                    state_d = S_KEYEXP;
`ifdef KEY_CACHE_EN
                    mkey_d = keys;
                    if (cache_valid_q && (keys == cache_key_q)) begin
                        k_d     = cache_rk_q;
                        cnt_d   = CNT_LAST;
                        state_d = S_DEC;
                    end
`endif
                end
            end
            S_KEYEXP: begin
                k_d = k_fwd;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DEC;
`ifdef KEY_CACHE_EN
                    cache_key_d   = mkey_q;
                    cache_rk_d    = k_fwd;
                    cache_valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DEC: begin
                d_d = inv_round(d_q ^ k_q[79:16]);
                k_d = inv_key_update(k_q, cnt_q);
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_FINISH: begin
                result_d = d_q ^ k_q[79:16];
                end_d    = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (!decrypt_start) begin
                    end_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            d_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
            end_q    <= 1'b0;
`ifdef KEY_CACHE_EN
            mkey_q        <= '0;
            cache_key_q   <= '0;
            cache_rk_q    <= '0;
            cache_valid_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            k_q      <= k_d;
            result_q <= result_d;
            end_q    <= end_d;
`ifdef KEY_CACHE_EN
            mkey_q        <= mkey_d;
            cache_key_q   <= cache_key_d;
            cache_rk_q    <= cache_rk_d;
            cache_valid_q <= cache_valid_d;
`endif
        end
    end

    assign decrypt_end = end_q;
    assign result      = result_q;
    assign busy        = (state_q == S_KEYEXP) || (state_q == S_DEC) || (state_q == S_FINISH);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ivlbc_decrypt.sv
// Directed bench for ivlbc_decrypt: ciphertexts come from a forward encryptor model built here.
module tb_ivlbc_decrypt;

    localparam int R = 25;
`ifdef KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        sys_clk;
    logic        rst_n;
    logic        decrypt_start;
    logic [63:0] state;
    logic [79:0] keys;
    logic        decrypt_end;
    logic [63:0] result;
    logic        busy;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    bit         cv = 1'b0;
    logic [79:0] ck = '0;

    ivlbc_decrypt #(.ROUNDS(R), .CNT_W(5)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .decrypt_start(decrypt_start),
        .state(state), .keys(keys), .decrypt_end(decrypt_end),
        .result(result), .busy(busy), .dbg_state(dbg_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] fsb(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;
        return tbl[x * 4 +: 4];
    endfunction

    // Forward cipher: d = round(d ^ RK[j]) for each round, final whitening with RK[ROUNDS].
    function automatic logic [63:0] enc(input logic [63:0] p, input logic [79:0] key);
        logic [79:0] k;
        logic [63:0] d;
        logic [63:0] s;
        logic [63:0] o;
        int          pos;
        k = key;
        d = p;
        for (int j = 0; j < R; j++) begin
            d = d ^ k[79:16];
            for (int n = 0; n < 16; n++) s[n * 4 +: 4] = fsb(d[n * 4 +: 4]);
            for (int i = 0; i < 64; i++) begin
                pos = (i == 63) ? 63 : (i * 16) % 63;
                o[pos] = s[i];
            end
            d = o;
            k = (k << 61) | (k >> 19);
            k[79:76] = fsb(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(j + 1);
        end
        return d ^ k[79:16];
    endfunction

    // hold < 0: one-cycle start pulse; otherwise start stays high through DONE for hold extra cycles.
    task automatic run_op(input string tag, input logic [79:0] key, input logic [63:0] pt, input int hold);
        int cyc;
        int exp_lat;
        bit busy_ok;
        bit stable;
        bit hit;
        hit = CACHE && cv && (key == ck);
        exp_lat = hit ? R + 1 : 2 * R + 1;
        keys = key;
        state = enc(pt, key);
        decrypt_start = 1'b1;
        @(negedge sys_clk);
        if (hold < 0) decrypt_start = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        while (!decrypt_end && cyc < 200) begin
            if (!busy) busy_ok = 1'b0;
            state = {$urandom, $urandom};
            keys  = {16'($urandom), $urandom, $urandom};
            @(negedge sys_clk);
            cyc++;
        end
        chk({tag, "_latency"}, 80'(cyc), 80'(exp_lat));
        chk({tag, "_busy_span"}, 80'(busy_ok), 80'(1));
        chk({tag, "_result"}, 80'(result), 80'(pt));
        chk({tag, "_busy_done"}, 80'(busy), 80'(0));
        if (!hit) begin
            cv = 1'b1;
            ck = key;
        end
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(negedge sys_clk);
                if (!decrypt_end || result !== pt || busy) stable = 1'b0;
            end
            chk({tag, "_held_no_retrigger"}, 80'(stable), 80'(1));
        end
        decrypt_start = 1'b0;
        @(negedge sys_clk);
        chk({tag, "_end_dropped"}, 80'(decrypt_end), 80'(0));
        chk({tag, "_back_idle"}, 80'(dbg_state), 80'(0));
    endtask

    initial begin
        logic [79:0] k6;
        logic [63:0] p_a;
        rst_n = 1'b0;
        decrypt_start = 1'b0;
        state = '0;
        keys = '0;
        repeat (3) @(negedge sys_clk);
        chk("reset_result", 80'(result), 80'(0));
        chk("reset_end", 80'(decrypt_end), 80'(0));
        chk("reset_busy", 80'(busy), 80'(0));
        chk("reset_fsm", 80'(dbg_state), 80'(0));
        rst_n = 1'b1;
        @(negedge sys_clk);

        run_op("all_ones", {80{1'b1}}, {64{1'b1}}, 0);
        run_op("all_zero", 80'h0, 64'h0, -1);
        for (int i = 0; i < 100; i++) begin
            run_op("sweep", {16'($urandom), $urandom, $urandom}, {$urandom, $urandom}, -1);
        end
        run_op("hold20", 80'h0123_4567_89AB_CDEF_0F1E, 64'hDEAD_BEEF_0BAD_F00D, 20);
        run_op("pulse_scramble", 80'h8000_0000_0000_0000_0001, 64'h0000_0000_0000_0001, -1);

        keys = 80'h1357_9BDF_2468_ACE0_FFEE;
        state = enc(64'hCAFE_BABE_1234_5678, keys);
        decrypt_start = 1'b1;
        @(negedge sys_clk);
        decrypt_start = 1'b0;
        repeat (30) @(negedge sys_clk);
        chk("mid_dec_fsm", 80'(dbg_state), 80'(2));
        rst_n = 1'b0;
        #1;
        chk("abort_result", 80'(result), 80'(0));
        chk("abort_end", 80'(decrypt_end), 80'(0));
        chk("abort_busy", 80'(busy), 80'(0));
        cv = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        run_op("after_abort", 80'h1357_9BDF_2468_ACE0_FFEE, 64'hCAFE_BABE_1234_5678, -1);

        k6 = 80'hA5A5_5A5A_C3C3_3C3C_9696;
        p_a = 64'h0F0F_F0F0_1111_EEEE;
        run_op("cache_first", k6, p_a, -1);
        run_op("cache_repeat", k6, ~p_a, -1);
        run_op("cache_newkey", k6 ^ 80'h1, p_a, -1);
        rst_n = 1'b0;
        cv = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        run_op("cache_after_reset", k6 ^ 80'h1, p_a, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ivlbc_decrypt.md
Name: ivlbc_decrypt

Overview:
Iterative IVLBC decryption core; inverse of the team's IVLBC encryptor (64-bit block, 80-bit key). It takes a ciphertext and the same 80-bit master key, and runs the key schedule forward to the final round key. It then applies the inverse rounds one per clock, walking the schedule backwards, and returns the plaintext. It uses the same level-start/end handshake as the encryptor, so the two cores can be chained back-to-back in the same bench or datapath.

Parameters:
ROUNDS, 25, number of cipher rounds; must equal the encryptor's round count.
CNT_W, 5, round-counter width; must satisfy 2^CNT_W > ROUNDS.

Ports:
sys_clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
decrypt_start  input  1  level request; sampled only in IDLE.
state  input  64  ciphertext; latched on the accepting edge.
keys  input  80  master key; latched on the accepting edge.
decrypt_end  output  1  high while result is valid (DONE state).
result  output  64  recovered plaintext; valid when decrypt_end is high.
busy  output  1  high in KEYEXP, DEC and FINISH.

Behaviour:
- Reset: asynchronous and active-low; one clock (sys_clk). While rst_n is low: result=0, decrypt_end=0, busy=0, FSM=IDLE, counters=0, internal data and key registers=0.
- Round functions: reuse the team's shared IVLBC round package.
  - key_update(k, i) computes RK[i] from RK[i-1].
  - inv_key_update(k, i) computes RK[i-1] from RK[i].
  - inv_round(d) is the inverse S-layer and P-layer of round().
- Encryption structure being inverted:
  - d = P; for j = 0..ROUNDS-1: d = round(d ^ RK[j]); C = d ^ RK[ROUNDS].
  - RK[0] = keys[79:16].
  - The key register holds the full 80-bit schedule state; the round key is its upper 64 bits.
- FSM states: IDLE, KEYEXP, DEC, FINISH, DONE.
  - IDLE: if decrypt_start=1 at an edge, latch d<=state, k<=keys, cnt<=1, and go to KEYEXP. Otherwise stay in IDLE.
  - KEYEXP: each edge k<=key_update(k, cnt). When cnt=ROUNDS, set cnt<=ROUNDS and go to DEC; else cnt<=cnt+1. Exactly ROUNDS edges are spent here, after which k holds RK[ROUNDS].
  - DEC: each edge d<=inv_round(d ^ k[79:16]) and k<=inv_key_update(k, cnt). When cnt=1, go to FINISH; else cnt<=cnt-1. Exactly ROUNDS edges are spent here, after which k holds RK[0].
  - FINISH: one edge; result<=d ^ k[79:16], decrypt_end<=1, go to DONE.
  - DONE: hold result and decrypt_end=1 while decrypt_start=1. On the first edge with decrypt_start=0, set decrypt_end<=0 and go to IDLE. result keeps its value until the next FINISH or reset.
- Latency: with the accepting edge as E0, decrypt_end rises after edge E0+2*ROUNDS+1 (51 cycles at the default).
- Handshake rules:
  - A start held high through DONE does not retrigger.
  - A new operation needs decrypt_start low for at least one edge in DONE or IDLE.
  - If decrypt_start drops mid-operation, the operation still completes. decrypt_end is high for exactly one cycle (DONE is entered and exited on the next edge).
- state and keys changing after E0 are ignored until the next accept.
- Reset asserted mid-operation aborts immediately; all outputs go to their reset values and no partial result is ever exposed.

Optional Feature:
KEY_CACHE_EN.
- Defined:
  - At the end of each KEYEXP, store the latched keys and RK[ROUNDS] in cache registers and set cache_valid.
  - On accept, if cache_valid=1 and keys equals the cached key, load k<=cached RK[ROUNDS], set cnt<=ROUNDS and go directly to DEC. Latency on a hit is ROUNDS+1 cycles after E0 (26 at the default).
  - cache_valid is cleared by reset.
- Undefined: no cache registers exist; every operation runs KEYEXP, and latency is always 2*ROUNDS+1.

Test Plan:
1. keys=80'hFFFF_FFFF_FFFF_FFFF_FFFF, state=encryptor output for plaintext 64'hFFFF_FFFF_FFFF_FFFF; start held until end -> result=64'hFFFF_FFFF_FFFF_FFFF; decrypt_end rises exactly 51 cycles after E0; busy high over that span.
2. Round-trip sweep with the encryptor on 100 random key/plaintext pairs plus the all-zero pair -> result equals the original plaintext every time.
3. decrypt_start held high for 20 cycles after decrypt_end rises -> no retrigger; result stable; decrypt_end stays high. Dropping start gives decrypt_end=0 on the next edge.
4. Pulse decrypt_start for 1 cycle; change state and keys during DEC -> result matches the originally latched inputs; decrypt_end high for exactly 1 cycle.
5. Assert rst_n=0 in DEC at cycle 30 -> result=0, decrypt_end=0, busy=0 immediately. After release, a fresh decrypt is correct with full latency.
6. KEY_CACHE_EN defined:
   - Second decrypt with the same keys -> decrypt_end after 26 cycles with a correct result.
   - Then a changed key -> full 51-cycle latency with a correct result.
   - Reset, then the same key -> 51 cycles.
